// File: rtl/axi4_to_apb_bridge_pkg.sv
// Shared encodings for the AXI4-to-APB bridge: FSM states, AXI response and burst codes.
package axi_apb_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WDATA  = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_ACCESS = 3'd3;
   localparam logic [2:0] ST_RRESP  = 3'd4;
   localparam logic [2:0] ST_BRESP  = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   function automatic logic [1:0] apb_resp(input logic slverr);
      return slverr ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi4_to_apb_bridge_if.sv
// Bus bundle between the 32-bit AXI4 upstream master, the bridge and its APB4 peripheral segment.
interface axi4_to_apb_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
);
   logic              in_awvalid;
   logic              in_awready;
   logic [ID_W-1:0]   in_awid;
   logic [ADDR_W-1:0] in_awaddr;
   logic [7:0]        in_awlen;
   logic [2:0]        in_awsize;
   logic [1:0]        in_awburst;

   logic              in_wvalid;
   logic              in_wready;
   logic [31:0]       in_wdata;
   logic [3:0]        in_wstrb;
   logic              in_wlast;

   logic              in_bvalid;
   logic              in_bready;
   logic [ID_W-1:0]   in_bid;
   logic [1:0]        in_bresp;

   logic              in_arvalid;
   logic              in_arready;
   logic [ID_W-1:0]   in_arid;
   logic [ADDR_W-1:0] in_araddr;
   logic [7:0]        in_arlen;
   logic [2:0]        in_arsize;
   logic [1:0]        in_arburst;

   logic              in_rvalid;
   logic              in_rready;
   logic [ID_W-1:0]   in_rid;
   logic [31:0]       in_rdata;
   logic [1:0]        in_rresp;
   logic              in_rlast;

   logic              apb_psel;
   logic              apb_penable;
   logic              apb_pwrite;
   logic [ADDR_W-1:0] apb_paddr;
   logic [31:0]       apb_pwdata;
   logic [3:0]        apb_pstrb;
   logic [2:0]        apb_pprot;
   logic              apb_pready;
   logic              apb_pslverr;
   logic [31:0]       apb_prdata;

   // Bridge view: AXI slave towards upstream, APB requester towards the peripherals.
   modport slave (
      input  in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
      output in_awready,
      input  in_wvalid, in_wdata, in_wstrb, in_wlast,
      output in_wready,
      output in_bvalid, in_bid, in_bresp,
      input  in_bready,
      input  in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
      output in_arready,
      output in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
      input  in_rready,
      output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot,
      input  apb_pready, apb_pslverr, apb_prdata
   );

   modport master (
      output in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
      input  in_awready,
      output in_wvalid, in_wdata, in_wstrb, in_wlast,
      input  in_wready,
      input  in_bvalid, in_bid, in_bresp,
      output in_bready,
      output in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
      input  in_arready,
      input  in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
      output in_rready,
      input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot,
      output apb_pready, apb_pslverr, apb_prdata
   );
endinterface

// File: rtl/axi4_to_apb_bridge.sv
// Serialises 32-bit AXI4 traffic into APB4 transfers, one APB access per AXI beat,
// with a single outstanding transaction and all outputs registered except the readies.
module axi4_to_apb_bridge
   import axi_apb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int ID_W     = 4,
   parameter bit RD_FIRST = 1'b1
) (
   input logic                  clock,
   input logic                  reset,
   axi4_to_apb_bridge_if.slave  bus
);

   logic [2:0]        state;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        cnt_q;
   logic [1:0]        burst_q;
   logic              err_q;
   logic              pwrite_q;
   logic              psel_q;
   logic              penable_q;
   logic [31:0]       pwdata_q;
   logic [3:0]        pstrb_q;
   logic              rvalid_q;
   logic              rlast_q;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   logic              ar_ready;
   logic              aw_ready;
   logic              unused_ok;

   // Beat size is always 32 bits and the beat counter decides the last beat.
   assign unused_ok = ^{bus.in_awsize, bus.in_arsize, bus.in_wlast};

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        burst);
      return (burst == BURST_FIXED) ? a : a + ADDR_W'(4);
   endfunction

   // Only the arbitration winner sees ready; the loser keeps its request pending.
   always_comb begin
      ar_ready = 1'b0;
      aw_ready = 1'b0;
      if (state == ST_IDLE) begin
         if (RD_FIRST) begin
            ar_ready = 1'b1;
            aw_ready = !bus.in_arvalid;
         end else begin
            aw_ready = 1'b1;
            ar_ready = !bus.in_awvalid;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         burst_q   <= '0;
         err_q     <= 1'b0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ar_ready && bus.in_arvalid) begin
                  id_q     <= bus.in_arid;
                  addr_q   <= bus.in_araddr;
                  cnt_q    <= bus.in_arlen;
                  burst_q  <= bus.in_arburst;
                  pwrite_q <= 1'b0;
                  pstrb_q  <= '0;
                  psel_q   <= 1'b1;
                  state    <= ST_SETUP;
               end else if (aw_ready && bus.in_awvalid) begin
                  id_q     <= bus.in_awid;
                  addr_q   <= bus.in_awaddr;
                  cnt_q    <= bus.in_awlen;
                  burst_q  <= bus.in_awburst;
                  pwrite_q <= 1'b1;
                  state    <= ST_WDATA;
               end
            end
            ST_WDATA: begin
               if (bus.in_wvalid) begin
                  pwdata_q <= bus.in_wdata;
                  pstrb_q  <= bus.in_wstrb;
                  psel_q   <= 1'b1;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.apb_pready) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (!pwrite_q) begin
                     rdata_q  <= bus.apb_prdata;
                     rresp_q  <= apb_resp(bus.apb_pslverr);
                     rlast_q  <= (cnt_q == 8'd0);
                     rvalid_q <= 1'b1;
                     state    <= ST_RRESP;
                  end else begin
                     err_q <= err_q | bus.apb_pslverr;
                     if (cnt_q == 8'd0) begin
                        bresp_q  <= apb_resp(err_q | bus.apb_pslverr);
                        bvalid_q <= 1'b1;
                        state    <= ST_BRESP;
                     end else begin
                        cnt_q  <= cnt_q - 8'd1;
                        addr_q <= next_addr(addr_q, burst_q);
                        state  <= ST_WDATA;
                     end
                  end
               end
            end
            ST_RRESP: begin
               if (bus.in_rready) begin
                  rvalid_q <= 1'b0;
                  if (rlast_q) begin
                     rlast_q <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     cnt_q  <= cnt_q - 8'd1;
                     addr_q <= next_addr(addr_q, burst_q);
                     psel_q <= 1'b1;
                     state  <= ST_SETUP;
                  end
               end
            end
            ST_BRESP: begin
               if (bus.in_bready) begin
                  bvalid_q <= 1'b0;
                  err_q    <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_arready  = ar_ready;
   assign bus.in_awready  = aw_ready;
   assign bus.in_wready   = (state == ST_WDATA);
   assign bus.in_bvalid   = bvalid_q;
   assign bus.in_bid      = id_q;
   assign bus.in_bresp    = bresp_q;
   assign bus.in_rvalid   = rvalid_q;
   assign bus.in_rid      = id_q;
   assign bus.in_rdata    = rdata_q;
   assign bus.in_rresp    = rresp_q;
   assign bus.in_rlast    = rlast_q;
   assign bus.apb_psel    = psel_q;
   assign bus.apb_penable = penable_q;
   assign bus.apb_pwrite  = pwrite_q;
   assign bus.apb_paddr   = addr_q;
   assign bus.apb_pwdata  = pwdata_q;
   assign bus.apb_pstrb   = pstrb_q;
   assign bus.apb_pprot   = 3'b000;

endmodule

// File: tb/tb_axi4_to_apb_bridge.sv
// Scoreboard bench for axi4_to_apb_bridge: drives AXI requests, plays the APB peripheral.
module tb_axi4_to_apb_bridge;
   import axi_apb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int ID_W   = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } r_t;

   typedef struct packed {
      logic [1:0] resp;
      logic [3:0] id;
   } b_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   apb_t exp_apb[$];
   r_t   exp_r[$];
   b_t   exp_b[$];

   always #5 clock = ~clock;

   axi4_to_apb_bridge_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus();

   axi4_to_apb_bridge #(.ADDR_W(ADDR_W), .ID_W(ID_W), .RD_FIRST(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic apb_t mk_apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                                   input logic [3:0] s);
      apb_t t;
      t.addr = a; t.wr = w; t.wdata = d; t.strb = s;
      return t;
   endfunction

   function automatic r_t mk_r(input logic [31:0] d, input logic [1:0] rs, input logic l,
                               input logic [3:0] i);
      r_t t;
      t.data = d; t.resp = rs; t.last = l; t.id = i;
      return t;
   endfunction

   function automatic b_t mk_b(input logic [1:0] rs, input logic [3:0] i);
      b_t t;
      t.resp = rs; t.id = i;
      return t;
   endfunction

   // Stimulus helpers: all are entered and left on a falling edge.
   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output bit ok);
      bus.in_arid = id; bus.in_araddr = addr; bus.in_arlen = len;
      bus.in_arburst = burst; bus.in_arsize = 3'd2; bus.in_arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (bus.in_arready) ok = 1'b1;
         @(negedge clock);
         if (ok) break;
      end
      bus.in_arvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output bit ok);
      bus.in_awid = id; bus.in_awaddr = addr; bus.in_awlen = len;
      bus.in_awburst = burst; bus.in_awsize = 3'd2; bus.in_awvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (bus.in_awready) ok = 1'b1;
         @(negedge clock);
         if (ok) break;
      end
      bus.in_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output bit ok);
      bus.in_wdata = data; bus.in_wstrb = strb; bus.in_wlast = 1'b0; bus.in_wvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (bus.in_wready) ok = 1'b1;
         @(negedge clock);
         if (ok) break;
      end
      bus.in_wvalid = 1'b0;
   endtask

   task automatic apb_serve(input int waits, input logic [31:0] rd, input logic err,
                            output apb_t obs, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.apb_psel && !bus.apb_penable) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      obs = mk_apb(bus.apb_paddr, bus.apb_pwrite, bus.apb_pwdata, bus.apb_pstrb);
      if (!ok) return;
      @(negedge clock);
      repeat (waits) @(negedge clock);
      bus.apb_pready = 1'b1; bus.apb_prdata = rd; bus.apb_pslverr = err;
      @(negedge clock);
      bus.apb_pready = 1'b0; bus.apb_prdata = '0; bus.apb_pslverr = 1'b0;
   endtask

   task automatic take_r(output r_t obs, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_rvalid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      obs = mk_r(bus.in_rdata, bus.in_rresp, bus.in_rlast, bus.in_rid);
      if (!ok) return;
      bus.in_rready = 1'b1;
      @(negedge clock);
      bus.in_rready = 1'b0;
   endtask

   task automatic take_b(output b_t obs, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_bvalid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      obs = mk_b(bus.in_bresp, bus.in_bid);
      if (!ok) return;
      bus.in_bready = 1'b1;
      @(negedge clock);
      bus.in_bready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      tests++;
      if ({bus.apb_psel, bus.apb_penable, bus.apb_pwrite, bus.in_rvalid, bus.in_bvalid,
           bus.in_rlast, bus.in_wready} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 0000000", {bus.apb_psel, bus.apb_penable,
                  bus.apb_pwrite, bus.in_rvalid, bus.in_bvalid, bus.in_rlast, bus.in_wready});
      end
      tests++;
      if ({bus.apb_paddr, bus.apb_pwdata, bus.apb_pstrb, bus.apb_pprot} !== '0) begin
         fails++;
         $display("FAIL reset_apb_data: got %h required 0",
                  {bus.apb_paddr, bus.apb_pwdata, bus.apb_pstrb, bus.apb_pprot});
      end
      tests++;
      if ({bus.in_rdata, bus.in_rresp, bus.in_rid, bus.in_bresp, bus.in_bid} !== '0) begin
         fails++;
         $display("FAIL reset_axi_data: got %h required 0",
                  {bus.in_rdata, bus.in_rresp, bus.in_rid, bus.in_bresp, bus.in_bid});
      end
      reset = 1'b1;
      @(negedge clock);
      tests++;
      if ({bus.in_arready, bus.in_awready} !== 2'b11) begin
         fails++;
         $display("FAIL reset_idle_ready: got %b required 11", {bus.in_arready, bus.in_awready});
      end
   endtask

   task automatic test_single_read();
      bit ok; apb_t oa, ea; r_t orr, er;
      exp_apb.push_back(mk_apb(32'h1000_0004, 1'b0, 32'h0, 4'h0));
      exp_r.push_back(mk_r(32'hDEAD_BEEF, RESP_OKAY, 1'b1, 4'd3));
      send_ar(4'd3, 32'h1000_0004, 8'd0, BURST_INCR, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL single_read_ar: handshake timeout"); end
      tests++;
      if (bus.in_rvalid !== 1'b0) begin
         fails++; $display("FAIL single_read_early_rvalid: got %b required 0", bus.in_rvalid);
      end
      apb_serve(0, 32'hDEAD_BEEF, 1'b0, oa, ok);
      ea = exp_apb.pop_front();
      tests++;
      if (!ok || {oa.addr, oa.wr, oa.strb} !== {ea.addr, ea.wr, ea.strb}) begin
         fails++; $display("FAIL single_read_apb: got %h required %h (ok=%0d)", oa, ea, ok);
      end
      tests++;
      if (bus.in_rvalid !== 1'b1) begin
         fails++; $display("FAIL single_read_latency: rvalid got %b required 1 at cycle 3",
                           bus.in_rvalid);
      end
      take_r(orr, ok);
      er = exp_r.pop_front();
      tests++;
      if (!ok || orr !== er) begin
         fails++; $display("FAIL single_read_r: got %h required %h (ok=%0d)", orr, er, ok);
      end
   endtask

   task automatic test_incr_write();
      bit ok, extra; apb_t oa, ea; b_t ob, eb;
      send_aw(4'd5, 32'h100, 8'd3, BURST_INCR, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL incr_write_aw: handshake timeout"); end
      for (int b = 0; b < 4; b++) begin
         exp_apb.push_back(mk_apb(32'h100 + 32'(4 * b), 1'b1, 32'(b + 1), 4'hF));
         send_w(32'(b + 1), 4'hF, ok);
         apb_serve(0, 32'h0, 1'b0, oa, ok);
         ea = exp_apb.pop_front();
         tests++;
         if (!ok || oa !== ea) begin
            fails++; $display("FAIL incr_write_apb%0d: got %h required %h (ok=%0d)", b, oa, ea, ok);
         end
      end
      exp_b.push_back(mk_b(RESP_OKAY, 4'd5));
      take_b(ob, ok);
      eb = exp_b.pop_front();
      tests++;
      if (!ok || ob !== eb) begin
         fails++; $display("FAIL incr_write_b: got %h required %h (ok=%0d)", ob, eb, ok);
      end
      extra = 1'b0;
      repeat (4) begin
         if (bus.in_bvalid || bus.apb_psel) extra = 1'b1;
         @(negedge clock);
      end
      tests++;
      if (extra !== 1'b0) begin
         fails++; $display("FAIL incr_write_extra: extra B/APB activity got %b required 0", extra);
      end
   endtask

   task automatic test_wait_error();
      bit ok; r_t orr, er;
      exp_r.push_back(mk_r(32'hCAFE_F00D, RESP_SLVERR, 1'b1, 4'd1));
      send_ar(4'd1, 32'h2000, 8'd0, BURST_INCR, ok);
      @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({bus.apb_psel, bus.apb_penable, bus.apb_paddr} !== {2'b11, 32'h2000}) begin
            fails++;
            $display("FAIL wait_state_hold%0d: got %b/%b/%h required 1/1/00002000", i,
                     bus.apb_psel, bus.apb_penable, bus.apb_paddr);
         end
         @(negedge clock);
      end
      bus.apb_pready = 1'b1; bus.apb_prdata = 32'hCAFE_F00D; bus.apb_pslverr = 1'b1;
      @(negedge clock);
      bus.apb_pready = 1'b0; bus.apb_prdata = '0; bus.apb_pslverr = 1'b0;
      take_r(orr, ok);
      er = exp_r.pop_front();
      tests++;
      if (!ok || orr !== er) begin
         fails++; $display("FAIL wait_error_r: got %h required %h (ok=%0d)", orr, er, ok);
      end
   endtask

   task automatic test_write_sticky();
      bit ok; apb_t oa; b_t ob, eb;
      exp_b.push_back(mk_b(RESP_SLVERR, 4'd2));
      send_aw(4'd2, 32'h300, 8'd1, BURST_INCR, ok);
      send_w(32'h11, 4'h3, ok);
      apb_serve(0, 32'h0, 1'b1, oa, ok);
      send_w(32'h22, 4'hC, ok);
      apb_serve(0, 32'h0, 1'b0, oa, ok);
      take_b(ob, ok);
      eb = exp_b.pop_front();
      tests++;
      if (!ok || ob !== eb) begin
         fails++; $display("FAIL sticky_err_b: got %h required %h (ok=%0d)", ob, eb, ok);
      end
      exp_b.push_back(mk_b(RESP_OKAY, 4'd9));
      send_aw(4'd9, 32'h400, 8'd0, BURST_INCR, ok);
      send_w(32'h33, 4'hF, ok);
      apb_serve(2, 32'h0, 1'b0, oa, ok);
      take_b(ob, ok);
      eb = exp_b.pop_front();
      tests++;
      if (!ok || ob !== eb) begin
         fails++; $display("FAIL sticky_clear_b: got %h required %h (ok=%0d)", ob, eb, ok);
      end
   endtask

   task automatic test_read_bursts();
      bit ok; apb_t oa, ea; r_t orr, er;
      logic [31:0] base [2];
      logic [1:0]  kind [2];
      base[0] = 32'h500;       kind[0] = BURST_FIXED;
      base[1] = 32'hFFFF_FFFC; kind[1] = BURST_INCR;
      for (int c = 0; c < 2; c++) begin
         send_ar(4'd4, base[c], 8'd2, kind[c], ok);
         for (int b = 0; b < 3; b++) begin
            exp_apb.push_back(mk_apb((kind[c] == BURST_FIXED) ? base[c] : base[c] + 32'(4 * b),
                                     1'b0, 32'h0, 4'h0));
            exp_r.push_back(mk_r(32'hA0 + 32'(b + 4 * c), RESP_OKAY, b == 2, 4'd4));
            apb_serve(b, 32'hA0 + 32'(b + 4 * c), 1'b0, oa, ok);
            ea = exp_apb.pop_front();
            tests++;
            if (!ok || {oa.addr, oa.wr, oa.strb} !== {ea.addr, ea.wr, ea.strb}) begin
               fails++;
               $display("FAIL burst%0d_apb%0d: got %h required %h (ok=%0d)", c, b, oa, ea, ok);
            end
            take_r(orr, ok);
            er = exp_r.pop_front();
            tests++;
            if (!ok || orr !== er) begin
               fails++;
               $display("FAIL burst%0d_r%0d: got %h required %h (ok=%0d)", c, b, orr, er, ok);
            end
         end
      end
   endtask

   task automatic test_arbitration();
      bit ok; apb_t oa, ea; r_t orr, er; b_t ob, eb;
      exp_apb.push_back(mk_apb(32'h800, 1'b0, 32'h0, 4'h0));
      exp_r.push_back(mk_r(32'h5555_AAAA, RESP_OKAY, 1'b1, 4'd6));
      exp_apb.push_back(mk_apb(32'h900, 1'b1, 32'h7777_0001, 4'h5));
      exp_b.push_back(mk_b(RESP_OKAY, 4'd8));
      bus.in_awid = 4'd8; bus.in_awaddr = 32'h900; bus.in_awlen = 8'd0;
      bus.in_awburst = BURST_INCR; bus.in_awvalid = 1'b1;
      bus.in_arid = 4'd6; bus.in_araddr = 32'h800; bus.in_arlen = 8'd0;
      bus.in_arburst = BURST_INCR; bus.in_arvalid = 1'b1;
      #1;
      tests++;
      if ({bus.in_arready, bus.in_awready} !== 2'b10) begin
         fails++; $display("FAIL arb_ready: got %b required 10", {bus.in_arready, bus.in_awready});
      end
      @(negedge clock);
      bus.in_arvalid = 1'b0;
      apb_serve(0, 32'h5555_AAAA, 1'b0, oa, ok);
      ea = exp_apb.pop_front();
      tests++;
      if (!ok || {oa.addr, oa.wr, oa.strb} !== {ea.addr, ea.wr, ea.strb}) begin
         fails++; $display("FAIL arb_first_apb: got %h required %h (ok=%0d)", oa, ea, ok);
      end
      take_r(orr, ok);
      er = exp_r.pop_front();
      tests++;
      if (!ok || orr !== er) begin
         fails++; $display("FAIL arb_first_r: got %h required %h (ok=%0d)", orr, er, ok);
      end
      send_aw(4'd8, 32'h900, 8'd0, BURST_INCR, ok);
      send_w(32'h7777_0001, 4'h5, ok);
      apb_serve(1, 32'h0, 1'b0, oa, ok);
      ea = exp_apb.pop_front();
      tests++;
      if (!ok || oa !== ea) begin
         fails++; $display("FAIL arb_second_apb: got %h required %h (ok=%0d)", oa, ea, ok);
      end
      take_b(ob, ok);
      eb = exp_b.pop_front();
      tests++;
      if (!ok || ob !== eb) begin
         fails++; $display("FAIL arb_second_b: got %h required %h (ok=%0d)", ob, eb, ok);
      end
   endtask

   task automatic test_backpressure();
      bit ok; apb_t oa; r_t orr, er;
      exp_r.push_back(mk_r(32'h1234_5678, RESP_OKAY, 1'b1, 4'd7));
      er = exp_r[0];
      send_ar(4'd7, 32'h600, 8'd0, BURST_INCR, ok);
      apb_serve(0, 32'h1234_5678, 1'b0, oa, ok);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({bus.in_rvalid, bus.in_rdata, bus.in_rresp, bus.in_rlast} !==
             {1'b1, er.data, er.resp, er.last}) begin
            fails++;
            $display("FAIL backpressure_hold%0d: got %b/%h/%b/%b required 1/%h/%b/%b", i,
                     bus.in_rvalid, bus.in_rdata, bus.in_rresp, bus.in_rlast,
                     er.data, er.resp, er.last);
         end
         @(negedge clock);
      end
      take_r(orr, ok);
      er = exp_r.pop_front();
      tests++;
      if (!ok || orr !== er) begin
         fails++; $display("FAIL backpressure_r: got %h required %h (ok=%0d)", orr, er, ok);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      send_ar(4'd2, 32'h700, 8'd0, BURST_INCR, ok);
      @(negedge clock);
      tests++;
      if ({bus.apb_psel, bus.apb_penable} !== 2'b11) begin
         fails++; $display("FAIL reset_mid_access: got %b required 11",
                           {bus.apb_psel, bus.apb_penable});
      end
      reset = 1'b0;
      #1;
      tests++;
      if ({bus.apb_psel, bus.apb_penable, bus.in_rvalid, bus.in_bvalid} !== 4'b0) begin
         fails++; $display("FAIL reset_mid_abort: got %b required 0000",
                           {bus.apb_psel, bus.apb_penable, bus.in_rvalid, bus.in_bvalid});
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      tests++;
      if ({bus.in_arready, bus.in_awready} !== 2'b11) begin
         fails++; $display("FAIL reset_mid_idle: got %b required 11",
                           {bus.in_arready, bus.in_awready});
      end
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (bus.in_rvalid || bus.apb_psel) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL reset_mid_no_resp: activity got %b required 0", seen);
      end
   endtask

   initial begin
      bus.in_awvalid = 1'b0; bus.in_awid = '0; bus.in_awaddr = '0; bus.in_awlen = '0;
      bus.in_awsize = '0; bus.in_awburst = '0;
      bus.in_wvalid = 1'b0; bus.in_wdata = '0; bus.in_wstrb = '0; bus.in_wlast = 1'b0;
      bus.in_bready = 1'b0;
      bus.in_arvalid = 1'b0; bus.in_arid = '0; bus.in_araddr = '0; bus.in_arlen = '0;
      bus.in_arsize = '0; bus.in_arburst = '0;
      bus.in_rready = 1'b0;
      bus.apb_pready = 1'b0; bus.apb_pslverr = 1'b0; bus.apb_prdata = '0;
      @(negedge clock);
      test_reset();
      test_single_read();
      test_incr_write();
      test_wait_error();
      test_write_sticky();
      test_read_bursts();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
